// File: rtl/index_mask_decoder.sv
// Rebuilds a WIDTH-bit mask from an AXI-Stream of bit indices (one per beat, framed by tlast).
// Optional duplicate-index detection on m_axis_tuser[1] when INDEX_MASK_DUP_DETECT_EN is defined.
module index_mask_decoder #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8,
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [IDXW-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [CNTW-1:0]  m_axis_tcount,
  output logic [1:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
);

  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  cnt;
  logic             oor;

  logic             accept;
  logic             in_range;
  logic [WIDTH-1:0] onehot;
  logic [CNTW-1:0]  cnt_inc;
  logic             oor_pkt;
  logic             dup_pkt;

  // The single output register frees up whenever it is empty or being drained this cycle.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Out-of-range indices only exist when WIDTH is not a power of two; they decode to zero.
  assign in_range = (32'(s_axis_tdata) < WIDTH);
  assign onehot   = in_range ? (WIDTH'(1) << s_axis_tdata) : '0;
  assign cnt_inc  = (&cnt) ? cnt : cnt + CNTW'(1);
  assign oor_pkt  = oor || !in_range;

`ifdef INDEX_MASK_DUP_DETECT_EN
  logic dup;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dup <= 1'b0;
    end else if (accept) begin
      dup <= s_axis_tlast ? 1'b0 : dup_pkt;
    end
  end

  assign dup_pkt = dup || (|(acc & onehot));
`else
  assign dup_pkt = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc           <= '0;
      cnt           <= '0;
      oor           <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tcount <= '0;
      m_axis_tuser  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        if (s_axis_tlast) begin
          // A last beat overrides the drain above, so back-to-back packets keep tvalid high.
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= acc | onehot;
          m_axis_tcount <= cnt_inc;
          m_axis_tuser  <= {dup_pkt, oor_pkt};
          acc           <= '0;
          cnt           <= '0;
          oor           <= 1'b0;
        end else begin
          acc <= acc | onehot;
          cnt <= cnt_inc;
          oor <= oor_pkt;
        end
      end
    end
  end

endmodule

// File: tb/tb_index_mask_decoder.sv
// Scoreboard bench for index_mask_decoder: directed packets push expected beats, monitors pop and compare.
// Instantiates a WIDTH=8 and a WIDTH=6 decoder sharing clock and reset.
module tb_index_mask_decoder;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] count;
    logic [1:0] user;
    int         cyc;
  } exp_t;

`ifdef INDEX_MASK_DUP_DETECT_EN
  localparam logic DUP = 1'b1;
`else
  localparam logic DUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aresetn;
  logic [2:0] s_tdata, s_tdata6;
  logic       s_tvalid, s_tvalid6, s_tlast, s_tlast6;
  logic       s_tready, s_tready6;
  logic [7:0] m_tdata;
  logic [5:0] m_tdata6;
  logic [7:0] m_tcount, m_tcount6;
  logic [1:0] m_tuser, m_tuser6;
  logic       m_tvalid, m_tvalid6;
  logic       m_tready, m_tready6;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  exp_t q8[$];
  exp_t q6[$];
  bit   pres8 = 0;
  bit   pres6 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  index_mask_decoder #(.WIDTH(8), .CNTW(8)) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tcount(m_tcount), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
  );

  index_mask_decoder #(.WIDTH(6), .CNTW(8)) dut6 (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata6), .s_axis_tvalid(s_tvalid6), .s_axis_tlast(s_tlast6),
    .s_axis_tready(s_tready6),
    .m_axis_tdata(m_tdata6), .m_axis_tcount(m_tcount6), .m_axis_tuser(m_tuser6),
    .m_axis_tvalid(m_tvalid6), .m_axis_tready(m_tready6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one beat on the selected DUT and wait (bounded) for its handshake.
  task automatic send(input int sel, input int idx, input bit last,
                      input logic [7:0] em, input logic [7:0] ec, input logic [1:0] eu);
    exp_t e;
    int   n = 0;
    if (sel == 0) begin
      s_tdata = idx[2:0]; s_tlast = last; s_tvalid = 1'b1;
    end else begin
      s_tdata6 = idx[2:0]; s_tlast6 = last; s_tvalid6 = 1'b1;
    end
    @(negedge clk);
    while (!((sel == 0) ? s_tready : s_tready6)) begin
      n++;
      stall_cnt++;
      if (n > 200) begin
        check("send_timeout_ready", (sel == 0) ? s_tready : s_tready6, 1);
        break;
      end
      @(negedge clk);
    end
    if (last) begin
      e.mask = em; e.count = ec; e.user = eu; e.cyc = cyc + 1;
      if (sel == 0) q8.push_back(e);
      else          q6.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel == 0) s_tvalid = 1'b0;
    else          s_tvalid6 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (aresetn && m_tvalid) begin
      if (q8.size() == 0) begin
        check("w8_spurious_valid", m_tvalid, 0);
      end else begin
        if (!pres8) begin
          check("w8_latency_cycle", cyc, q8[0].cyc);
          pres8 = 1;
        end
        check("w8_tdata", m_tdata, q8[0].mask);
        check("w8_tcount", m_tcount, q8[0].count);
        check("w8_tuser", m_tuser, q8[0].user);
        if (m_tready) begin
          void'(q8.pop_front());
          pres8 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (aresetn && m_tvalid6) begin
      if (q6.size() == 0) begin
        check("w6_spurious_valid", m_tvalid6, 0);
      end else begin
        if (!pres6) begin
          check("w6_latency_cycle", cyc, q6[0].cyc);
          pres6 = 1;
        end
        check("w6_tdata", {2'b00, m_tdata6}, q6[0].mask);
        check("w6_tcount", m_tcount6, q6[0].count);
        check("w6_tuser", m_tuser6, q6[0].user);
        if (m_tready6) begin
          void'(q6.pop_front());
          pres6 = 0;
        end
      end
    end
  end

  initial begin
    int s0;
    aresetn = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    s_tdata6 = '0; s_tvalid6 = 1'b0; s_tlast6 = 1'b0; m_tready6 = 1'b1;
    #12;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tcount", m_tcount, 0);
    check("rst_tuser", m_tuser, 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_tready, 1);
    @(posedge clk);
    #1;

    // Basic three-beat packet.
    send(0, 3, 0, 8'h00, 8'd0, 2'b00);
    send(0, 0, 0, 8'h00, 8'd0, 2'b00);
    send(0, 7, 1, 8'h89, 8'd3, 2'b00);
    repeat (3) @(posedge clk);
    #1;

    // Single-beat packets back to back at full rate.
    s0 = stall_cnt;
    for (int i = 0; i < 8; i++) send(0, i, 1, 8'(1 << i), 8'd1, 2'b00);
    check("b2b_no_stall", stall_cnt - s0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Downstream backpressure: first mask held, second packet stalls until ack.
    m_tready = 1'b0;
    send(0, 5, 1, 8'h20, 8'd1, 2'b00);
    fork
      send(0, 2, 1, 8'h04, 8'd1, 2'b00);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_s_ready", s_tready, 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Repeated index within a packet.
    send(0, 4, 0, 8'h00, 8'd0, 2'b00);
    send(0, 4, 0, 8'h00, 8'd0, 2'b00);
    send(0, 1, 1, 8'h12, 8'd3, {DUP, 1'b0});
    repeat (3) @(posedge clk);
    #1;

    // Beat-count saturation: 301 beats, count pinned at 255, mask fully set.
    for (int i = 0; i < 300; i++) send(0, i % 8, 0, 8'h00, 8'd0, 2'b00);
    send(0, 0, 1, 8'hFF, 8'd255, {DUP, 1'b0});
    repeat (3) @(posedge clk);
    #1;

    // Non-power-of-two width with an out-of-range index.
    send(1, 2, 0, 8'h00, 8'd0, 2'b00);
    send(1, 7, 1, 8'h04, 8'd2, 2'b01);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a packet discards the partial mask.
    send(0, 1, 0, 8'h00, 8'd0, 2'b00);
    send(0, 6, 0, 8'h00, 8'd0, 2'b00);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_tdata", m_tdata, 0);
    check("midrst_tcount", m_tcount, 0);
    check("midrst_tuser", m_tuser, 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    send(0, 0, 1, 8'h01, 8'd1, 2'b00);

    for (int i = 0; i < 50 && (q8.size() != 0 || q6.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check("sb8_drained", q8.size(), 0);
    check("sb6_drained", q6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
